draw_character: RTL and testbench

DRAW_CHARACTER -- requirements
Module: draw_character

---
 rtl/draw_character.sv | 213 +++++++++++++++++++++
 tb/tb_draw_character.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_character.sv
// ---------------------------------------------------------------------------
// draw_character
//
// Scans a 9x5 character bitmap (SPRITE) out to a VGA adapter, one pixel per
// clock, row-major, at one of four fixed screen positions.
//
// Parameters:
//   SPRITE      45-bit bitmap, bit index = row*9 + col, bit 0 = top-left
//   CHAR_COLOR  colour of pixels whose sprite bit is 1
//   BG_COLOR    colour of pixels whose sprite bit is 0
//
// Ports:
//   Clock        in   rising-edge clock
//   Reset        in   asynchronous active-low reset
//   Start        in   draw request, honoured only while idle
//   NextState    in   [3:0] position code (0..3 valid, 4..15 invalid)
//   XOut         out  [7:0] pixel x coordinate (registered)
//   YOut         out  [6:0] pixel y coordinate (registered)
//   Color        out  [2:0] pixel colour (registered)
//   Plot         out  pixel write strobe (registered)
//   Busy         out  high whenever the FSM is not idle
//   DoneDrawing  out  one-cycle completion pulse
//
// Build option:
//   DRAW_CHARACTER_TRANSPARENT_EN  when defined, background pixels are not
//   plotted (Plot=0 where the sprite bit is 0); the scan still takes 45
//   cycles so completion timing is identical in both builds.
// ---------------------------------------------------------------------------
module draw_character #(
    parameter logic [44:0] SPRITE     = 45'h0_0000_0000,
    parameter logic [2:0]  CHAR_COLOR = 3'b100,
    parameter logic [2:0]  BG_COLOR   = 3'b111
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic [3:0] NextState,
    output logic [7:0] XOut,
    output logic [6:0] YOut,
    output logic [2:0] Color,
    output logic       Plot,
    output logic       Busy,
    output logic       DoneDrawing
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [6:0] BASE_Y = 7'd102;
    localparam logic [3:0] LAST_COL = 4'd8;
    localparam logic [2:0] LAST_ROW = 3'd4;

    state_t      state_reg, state_next;
    logic [1:0]  code_reg, code_next;
    logic [3:0]  col_reg, col_next;
    logic [2:0]  row_reg, row_next;
    logic [5:0]  idx_reg, idx_next;
    logic [7:0]  x_reg, x_next;
    logic [6:0]  y_reg, y_next;
    logic [2:0]  color_reg, color_next;
    logic        plot_reg, plot_next;
    logic        done_reg, done_next;

    logic [44:0] sprite_vec;
    assign sprite_vec = SPRITE;

    function automatic logic [7:0] base_x(input logic [1:0] code);
        logic [7:0] bx;
        case (code)
            2'd0:    bx = 8'd6;
            2'd1:    bx = 8'd24;
            2'd2:    bx = 8'd78;
            default: bx = 8'd132;
        endcase
        return bx;
    endfunction

    // Position of the pixel following the current one in row-major order.
    logic [3:0] adv_col;
    logic [2:0] adv_row;
    logic [5:0] adv_idx;
    logic       at_last;

    always_comb begin
        at_last = (col_reg == LAST_COL) && (row_reg == LAST_ROW);
        adv_idx = idx_reg + 6'd1;
        if (col_reg == LAST_COL) begin
            adv_col = 4'd0;
            adv_row = row_reg + 3'd1;
        end else begin
            adv_col = col_reg + 4'd1;
            adv_row = row_reg;
        end
    end

    // Next-state and output logic. Whenever a pixel is to be presented at the
    // coming edge, 'load' is set and tgt_* name that pixel.
    logic       load;
    logic [1:0] tgt_code;
    logic [3:0] tgt_col;
    logic [2:0] tgt_row;
    logic [5:0] tgt_idx;
    logic       pix_bit;

    always_comb begin
        state_next = state_reg;
        code_next  = code_reg;
        col_next   = col_reg;
        row_next   = row_reg;
        idx_next   = idx_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        color_next = color_reg;
        plot_next  = 1'b0;
        done_next  = 1'b0;
        load       = 1'b0;
        tgt_code   = code_reg;
        tgt_col    = 4'd0;
        tgt_row    = 3'd0;
        tgt_idx    = 6'd0;
        pix_bit    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (Start) begin
                    if (NextState[3:2] == 2'b00) begin
                        state_next = DRAW;
                        code_next  = NextState[1:0];
                        col_next   = 4'd0;
                        row_next   = 3'd0;
                        idx_next   = 6'd0;
                        load       = 1'b1;
                        tgt_code   = NextState[1:0];
                    end else begin
                        // Invalid position: skip the scan entirely.
                        state_next = DONE;
                        done_next  = 1'b1;
                    end
                end
            end
            DRAW: begin
                if (at_last) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end else begin
                    col_next = adv_col;
                    row_next = adv_row;
                    idx_next = adv_idx;
                    load     = 1'b1;
                    tgt_col  = adv_col;
                    tgt_row  = adv_row;
                    tgt_idx  = adv_idx;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (load) begin
            pix_bit = sprite_vec[tgt_idx];
            x_next  = base_x(tgt_code) + {4'b0000, tgt_col};
            y_next  = BASE_Y + {4'b0000, tgt_row};
`ifdef DRAW_CHARACTER_TRANSPARENT_EN
            plot_next  = pix_bit;
            color_next = CHAR_COLOR;
`else
            plot_next  = 1'b1;
            color_next = pix_bit ? CHAR_COLOR : BG_COLOR;
`endif
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_reg <= IDLE;
            code_reg  <= 2'd0;
            col_reg   <= 4'd0;
            row_reg   <= 3'd0;
            idx_reg   <= 6'd0;
            x_reg     <= 8'd0;
            y_reg     <= 7'd0;
            color_reg <= 3'd0;
            plot_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            code_reg  <= code_next;
            col_reg   <= col_next;
            row_reg   <= row_next;
            idx_reg   <= idx_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            color_reg <= color_next;
            plot_reg  <= plot_next;
            done_reg  <= done_next;
        end
    end

    assign XOut        = x_reg;
    assign YOut        = y_reg;
    assign Color       = color_reg;
    assign Plot        = plot_reg;
    assign Busy        = (state_reg != IDLE);
    assign DoneDrawing = done_reg;

endmodule

// File: tb/tb_draw_character.sv
// ---------------------------------------------------------------------------
// tb_draw_character
//
// Scoreboard bench for draw_character. The stimulus process pushes every
// expected pixel (coordinate, colour, cycle) and every expected DoneDrawing
// cycle into queues; a monitor sampling on the falling edge pops and compares
// whenever Plot or DoneDrawing is high. Honours DRAW_CHARACTER_TRANSPARENT_EN.
// ---------------------------------------------------------------------------
module tb_draw_character;

    localparam logic [44:0] SPRITE_TB = 45'h1A_5C3F_0E81;
    localparam logic [2:0]  CHAR_TB   = 3'b100;
    localparam logic [2:0]  BG_TB     = 3'b111;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       Start = 1'b0;
    logic [3:0] NextState = 4'd0;
    logic [7:0] XOut;
    logic [6:0] YOut;
    logic [2:0] Color;
    logic       Plot;
    logic       Busy;
    logic       DoneDrawing;

    draw_character #(
        .SPRITE     (SPRITE_TB),
        .CHAR_COLOR (CHAR_TB),
        .BG_COLOR   (BG_TB)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Start       (Start),
        .NextState   (NextState),
        .XOut        (XOut),
        .YOut        (YOut),
        .Color       (Color),
        .Plot        (Plot),
        .Busy        (Busy),
        .DoneDrawing (DoneDrawing)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        int x;
        int y;
        int c;
        int t;
    } pix_t;

    pix_t pix_q[$];
    int   done_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int base_of(input int code);
        case (code)
            0:       return 6;
            1:       return 24;
            2:       return 78;
            default: return 132;
        endcase
    endfunction

    // Queue the expected pixels 0..npix-1 of a draw accepted with cycle stamp acc.
    task automatic push_draw(input int code, input int acc, input int npix, input bit with_done);
        logic [44:0] spr;
        pix_t p;
        spr = SPRITE_TB;
        for (int k = 0; k < npix; k++) begin
            p.x = base_of(code) + (k % 9);
            p.y = 102 + (k / 9);
            p.t = acc + k;
`ifdef DRAW_CHARACTER_TRANSPARENT_EN
            p.c = int'(CHAR_TB);
            if (spr[k]) pix_q.push_back(p);
`else
            p.c = spr[k] ? int'(CHAR_TB) : int'(BG_TB);
            pix_q.push_back(p);
`endif
        end
        if (with_done) done_q.push_back(acc + 45);
    endtask

    // Pulse Start for one accepting edge; acc is the cycle stamp after it.
    task automatic start_draw(input logic [3:0] code, output int acc);
        @(posedge Clock);
        #1;
        Start = 1'b1;
        NextState = code;
        @(posedge Clock);
        #1;
        acc = cyc;
        Start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!Busy) break;
            @(posedge Clock);
            #1;
        end
        check("wait_idle_timeout", {31'd0, Busy}, 32'd0);
    endtask

    // Monitor / scoreboard
    initial begin
        pix_t p;
        int   t;
        forever begin
            @(negedge Clock);
            if (Plot === 1'b1) begin
                if (pix_q.size() == 0) begin
                    check("plot_unexpected", {31'd0, Plot}, 32'd0);
                end else begin
                    p = pix_q.pop_front();
                    check("pix_x", {24'd0, XOut}, p.x);
                    check("pix_y", {25'd0, YOut}, p.y);
                    check("pix_color", {29'd0, Color}, p.c);
                    check("pix_cycle", cyc, p.t);
                end
            end
            if (DoneDrawing === 1'b1) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", {31'd0, DoneDrawing}, 32'd0);
                end else begin
                    t = done_q.pop_front();
                    check("done_cycle", cyc, t);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int a2;

        // Reset state
        #2;
        check("rst_x", {24'd0, XOut}, 0);
        check("rst_y", {25'd0, YOut}, 0);
        check("rst_color", {29'd0, Color}, 0);
        check("rst_plot", {31'd0, Plot}, 0);
        check("rst_busy", {31'd0, Busy}, 0);
        check("rst_done", {31'd0, DoneDrawing}, 0);
        repeat (3) @(posedge Clock);
        #1;
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        check("idle_busy", {31'd0, Busy}, 0);

        // Full draw at position 2
        start_draw(4'd2, a);
        push_draw(2, a, 45, 1'b1);
        check("draw2_busy", {31'd0, Busy}, 1);
        repeat (45) @(posedge Clock);
        #1;
        check("draw2_done_state_busy", {31'd0, Busy}, 1);
        check("draw2_done_plot", {31'd0, Plot}, 0);
        check("draw2_hold_x", {24'd0, XOut}, 86);
        check("draw2_hold_y", {25'd0, YOut}, 106);
        @(posedge Clock);
        #1;
        check("draw2_idle_busy", {31'd0, Busy}, 0);

        // Invalid codes: straight to DONE, no pixels
        start_draw(4'd9, a);
        done_q.push_back(a);
        check("inv9_busy", {31'd0, Busy}, 1);
        @(posedge Clock);
        #1;
        check("inv9_busy_after", {31'd0, Busy}, 0);
        start_draw(4'd15, a);
        done_q.push_back(a);
        @(posedge Clock);
        #1;
        check("inv15_busy_after", {31'd0, Busy}, 0);

        // Reset mid-draw after pixel 20
        start_draw(4'd0, a);
        push_draw(0, a, 21, 1'b0);
        repeat (20) @(posedge Clock);
        #1;
        @(negedge Clock);
        #1;
        Reset = 1'b0;
        #1;
        check("midrst_x", {24'd0, XOut}, 0);
        check("midrst_y", {25'd0, YOut}, 0);
        check("midrst_color", {29'd0, Color}, 0);
        check("midrst_plot", {31'd0, Plot}, 0);
        check("midrst_busy", {31'd0, Busy}, 0);
        check("midrst_done", {31'd0, DoneDrawing}, 0);
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        check("postrst_busy", {31'd0, Busy}, 0);
        start_draw(4'd3, a);
        push_draw(3, a, 45, 1'b1);
        wait_idle();

        // Start held high, NextState disturbed mid-draw
        @(posedge Clock);
        #1;
        Start = 1'b1;
        NextState = 4'd1;
        @(posedge Clock);
        #1;
        a = cyc;
        push_draw(1, a, 45, 1'b1);
        repeat (10) @(posedge Clock);
        #1;
        NextState = 4'd3;
        repeat (20) @(posedge Clock);
        #1;
        NextState = 4'd1;
        repeat (17) @(posedge Clock);
        #1;
        a2 = cyc;
        check("b2b_period", a2 - a, 47);
        check("b2b_second_busy", {31'd0, Busy}, 1);
        push_draw(1, a2, 45, 1'b1);
        Start = 1'b0;
        wait_idle();

        repeat (5) @(posedge Clock);
        #1;
        check("pix_queue_empty", pix_q.size(), 0);
        check("done_queue_empty", done_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
